// File: rtl/aer_event_packer_if.sv
`default_nettype none
// ============================================================================
// Module      : aer_event_packer_if
// Description : Arbiter-side event inputs and AER packet stream of the packer.
// Revision    : 1.0 - initial release
// ============================================================================
interface aer_event_packer_if #(
    parameter int ADDR_W = 4,
    parameter int TS_W   = 16,
    parameter int PKT_W  = 2*ADDR_W+TS_W+2
) ();
    logic              evt_valid_i;
    logic [ADDR_W-1:0] x_add_i;
    logic [ADDR_W-1:0] y_add_i;
    logic              polarity_i;
    logic              stall_o;
    logic              pkt_valid_o;
    logic              pkt_ready_i;
    logic [PKT_W-1:0]  pkt_data_o;

    // master: the packer, which sources AER packets and throttles the arbiter
    modport master (
        input  evt_valid_i, x_add_i, y_add_i, polarity_i, pkt_ready_i,
        output stall_o, pkt_valid_o, pkt_data_o
    );

    modport slave (
        output evt_valid_i, x_add_i, y_add_i, polarity_i, pkt_ready_i,
        input  stall_o, pkt_valid_o, pkt_data_o
    );
endinterface
`default_nettype wire

// File: rtl/aer_event_packer.sv
`default_nettype none
// ============================================================================
// Module      : aer_event_packer
// Description : Timestamps arbiter grants, buffers them with time-wrap markers
//               in a show-ahead FIFO and streams AER packets.
// Revision    : 1.0 - initial release
// ============================================================================
module aer_event_packer #(
    parameter int ADDR_W = 4,
    parameter int TS_W   = 16,
    parameter int DEPTH  = 8,
    parameter int PKT_W  = 2*ADDR_W+TS_W+2
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     enable_i,
    aer_event_packer_if.master       aer,
    output logic [$clog2(DEPTH):0]   fifo_count_o,
    output logic [TS_W-1:0]          ts_o,
    output logic                     overflow_o
);

    localparam int                 c_PTR_W     = $clog2(DEPTH);
    localparam int                 c_CNT_W     = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH     = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_STALL_LVL = c_CNT_W'(DEPTH - 2);
    localparam logic [TS_W-1:0]    c_TS_MAX    = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [PKT_W-1:0]     r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic [TS_W-1:0]      r_ts, r_wrap_cnt;
    logic                 r_marker_pending, r_skid_valid, r_overflow;
    logic [PKT_W-1:0]     r_skid_data;

    logic                 w_live, w_full, w_empty, w_rd, w_wr, w_wrap;
    logic                 w_wr_marker, w_wr_skid, w_wr_live, w_skid_load, w_drop;
    logic [PKT_W-1:0]     w_wr_data, w_evt_pkt, w_mrk_pkt;

    assign w_live    = aer.evt_valid_i && (r_state == S_RUN);
    assign w_full    = (r_count == c_DEPTH);
    assign w_empty   = (r_count == '0);
    assign w_rd      = !w_empty && aer.pkt_ready_i;
    assign w_wrap    = (r_state == S_RUN) && (r_ts == c_TS_MAX);
    assign w_evt_pkt = {1'b0, aer.x_add_i, aer.y_add_i, aer.polarity_i, r_ts};
    assign w_mrk_pkt = {1'b1, {(2*ADDR_W+1){1'b0}}, r_wrap_cnt};

    // Single write port: marker beats skid beats live event
    always_comb begin
        w_wr_marker = 1'b0;
        w_wr_skid   = 1'b0;
        w_wr_live   = 1'b0;
        w_wr_data   = w_evt_pkt;
        if (!w_full) begin
            if (r_marker_pending) begin
                w_wr_marker = 1'b1;
                w_wr_data   = w_mrk_pkt;
            end else if (r_skid_valid) begin
                w_wr_skid   = 1'b1;
                w_wr_data   = r_skid_data;
            end else if (w_live) begin
                w_wr_live   = 1'b1;
            end
        end
        w_wr        = w_wr_marker || w_wr_skid || w_wr_live;
        // A skid entry leaving on this edge frees the slot for the new event
        w_skid_load = w_live && !w_wr_live && (!r_skid_valid || w_wr_skid);
        w_drop      = w_live && !w_wr_live && r_skid_valid && !w_wr_skid;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (enable_i) w_state_nxt = S_RUN;
            S_RUN:   if (!enable_i) w_state_nxt = S_DRAIN;
            S_DRAIN: begin
                if (enable_i)
                    w_state_nxt = S_RUN;
                else if (w_empty && !r_skid_valid && !r_marker_pending)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state          <= S_IDLE;
            r_wr_ptr         <= '0;
            r_rd_ptr         <= '0;
            r_count          <= '0;
            r_ts             <= '0;
            r_wrap_cnt       <= '0;
            r_marker_pending <= 1'b0;
            r_skid_valid     <= 1'b0;
            r_skid_data      <= '0;
            r_overflow       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_wr) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            r_count <= r_count + c_CNT_W'(w_wr) - c_CNT_W'(w_rd);

            case (r_state)
                S_RUN: begin
                    r_ts <= r_ts + TS_W'(1);
                    if (w_wrap) r_wrap_cnt <= r_wrap_cnt + TS_W'(1);
                end
                S_DRAIN: begin
                    if (w_state_nxt == S_IDLE) begin
                        r_ts       <= '0;
                        r_wrap_cnt <= '0;
                    end
                end
                default: begin
                    r_ts       <= '0;
                    r_wrap_cnt <= '0;
                end
            endcase

            r_marker_pending <= w_wrap || (r_marker_pending && !w_wr_marker);

            if (w_skid_load) begin
                r_skid_valid <= 1'b1;
                r_skid_data  <= w_evt_pkt;
            end else if (w_wr_skid) begin
                r_skid_valid <= 1'b0;
            end

            if (w_drop) r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_wr) r_mem[r_wr_ptr] <= w_wr_data;
    end

    assign aer.stall_o     = (r_count >= c_STALL_LVL) || r_skid_valid || r_marker_pending;
    assign aer.pkt_valid_o = !w_empty;
    assign aer.pkt_data_o  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign fifo_count_o    = r_count;
    assign ts_o            = r_ts;
    assign overflow_o      = r_overflow;

endmodule
`default_nettype wire
